comparator_4b_bist: RTL and testbench

- Self-test sequencer that drives the opposite end of the 4-bit magnitude comparator interface.
- Generates every A/B operand pair, presents it to an external comparator instance, and samples the three result flags.
- Checks each sample against an internal golden model, then reports error count, first failing vector, and pass/fail.
- Sits beside comparator_4b_behavioral in on-chip self-test and in integration benches.

---
 rtl/comparator_4b_bist.sv | 146 ++++++++++++++
 tb/tb_comparator_4b_bist.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/comparator_4b_bist.sv
// Self-test sequencer for a 4-bit magnitude comparator: sweeps all A/B pairs,
// checks the returned flags against a golden model and reports the results.
// Optional macro COMP4B_BIST_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module comparator_4b_bist #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             a_great_b_in,
    input  logic             a_equal_b_in,
    input  logic             a_less_b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0]         SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0]   ERR_SAT    = '1;
    localparam logic [ERR_W-1:0]   ERR_ONE    = ERR_W'(1);
    localparam logic [2*WIDTH-1:0] VEC_ONE    = (2*WIDTH)'(1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         settle_cnt;
    logic [2*WIDTH-1:0] vec;
    logic               sample;
    logic               last_vec;
    logic               exp_gt;
    logic               exp_eq;
    logic               exp_lt;
    logic               mismatch;
    logic               stop_now;
    logic [ERR_W-1:0]   err_next;

    assign vec = {a_out, b_out};

    // Golden model and sample/terminate decisions for the current RUN edge.
    always_comb begin
        sample   = (state == S_RUN) && (settle_cnt == SETTLE_MAX);
        last_vec = &vec;
        exp_gt   = a_out > b_out;
        exp_eq   = a_out == b_out;
        exp_lt   = a_out < b_out;
        mismatch = sample &&
                   ({a_great_b_in, a_equal_b_in, a_less_b_in} != {exp_gt, exp_eq, exp_lt});
        err_next = err_count;
        if (mismatch && (err_count != ERR_SAT)) begin
            err_next = err_count + ERR_ONE;
        end
`ifdef COMP4B_BIST_STOP_ON_FAIL_EN
        stop_now = sample && (last_vec || mismatch);
`else
        stop_now = sample && last_vec;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_now) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= '0;
            b_out      <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_out      <= '0;
                        b_out      <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!sample) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        err_count <= err_next;
                        // An empty error count marks the first failure of this sweep.
                        if (mismatch && (err_count == '0)) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                        if (stop_now) begin
                            pass <= (err_next == '0);
                        end else begin
                            {a_out, b_out} <= vec + VEC_ONE;
                            settle_cnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_4b_bist.sv
// Directed bench for comparator_4b_bist: a behavioural comparator with
// injectable faults answers the sweep; results are checked against a table.
module tb_comparator_4b_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       gt;
    logic       eq;
    logic       lt;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [3:0] fail_a;
    logic [3:0] fail_b;

    int unsigned fault;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    comparator_4b_bist #(
        .WIDTH(4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a_out(a_out),
        .b_out(b_out),
        .a_great_b_in(gt),
        .a_equal_b_in(eq),
        .a_less_b_in(lt),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_a(fail_a),
        .fail_b(fail_b)
    );

    // Comparator under test: 0 = correct, 1 = eq stuck at 0, 2 = gt/lt swapped.
    always_comb begin
        gt = a_out > b_out;
        eq = a_out == b_out;
        lt = a_out < b_out;
        if (fault == 1) begin
            eq = 1'b0;
        end else if (fault == 2) begin
            gt = a_out < b_out;
            lt = a_out > b_out;
        end
    end

    typedef struct {
        int unsigned fault;
        int unsigned cycles;
        int unsigned err;
        int unsigned fa;
        int unsigned fb;
        int unsigned ps;
        int unsigned a_end;
        int unsigned b_end;
    } vec_t;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then count clocks until done. inject_at pulses start while busy;
    // abort_at applies reset mid-sweep and checks the cleared outputs.
    task automatic run_sweep(input vec_t v, input int inject_at, input int abort_at);
        int unsigned cnt;
        bit          seen;
        fault = v.fault;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", err_count, 0);
        check("start_fail_clr", {fail_a, fail_b}, 0);
        check("start_done_clr", done, 0);
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 2000 && !seen) begin
            @(posedge clk);
            #1;
            cnt++;
            start = (inject_at >= 0 && cnt == 99) ? 1'b1 : 1'b0;
            if (abort_at >= 0 && cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", {a_out, b_out, fail_a, fail_b}, 0);
                check("abort_err", err_count, 0);
                check("abort_flags", {busy, done, pass}, 0);
                #2;
                rst_n = 1'b1;
                return;
            end
            seen = done;
        end
        start = 1'b0;
        check("done_cycles", cnt, v.cycles);
        check("end_busy", busy, 0);
        check("end_err", err_count, v.err);
        check("end_fail_a", fail_a, v.fa);
        check("end_fail_b", fail_b, v.fb);
        check("end_pass", pass, v.ps);
        check("end_vec", {a_out, b_out}, (v.a_end << 4) | v.b_end);
    endtask

    vec_t tbl[4];
    vec_t good;

    initial begin
`ifdef COMP4B_BIST_STOP_ON_FAIL_EN
        tbl[0] = '{0, 768, 0,   0, 0, 1, 15, 15};
        tbl[1] = '{1, 3,   1,   0, 0, 0, 0,  0};
        tbl[2] = '{2, 6,   1,   0, 1, 0, 0,  1};
        tbl[3] = '{0, 768, 0,   0, 0, 1, 15, 15};
`else
        tbl[0] = '{0, 768, 0,   0, 0, 1, 15, 15};
        tbl[1] = '{1, 768, 16,  0, 0, 0, 15, 15};
        tbl[2] = '{2, 768, 240, 0, 1, 0, 15, 15};
        tbl[3] = '{0, 768, 0,   0, 0, 1, 15, 15};
`endif
        good  = tbl[0];
        fault = 0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {a_out, b_out, fail_a, fail_b}, 0);
        check("rst_err", err_count, 0);
        check("rst_flags", {busy, done, pass}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold", {busy, done}, 0);

        // Last entry restarts from DONE after a failing sweep.
        for (int i = 0; i < 4; i++) begin
            run_sweep(tbl[i], -1, -1);
            repeat (3) @(posedge clk);
            #1;
            check("done_hold", {done, busy}, 2'b10);
        end

        run_sweep(good, 100, -1);
        run_sweep(good, -1, 300);
        @(posedge clk);
        #1;
        check("post_abort_idle", {busy, done}, 0);
        run_sweep(good, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
